mem_stage_be: RTL

- Next-generation MIPS MEM pipeline stage with byte-lane-correct SB/SH stores and address-offset-aware LB/LH loads.
- Adds misalignment detection, configurable data-memory wait states with a stall handshake to the hazard unit, and a debug read port.
- Sits between the EX/MEM and MEM/WB boundaries; it owns the MEM/WB pipeline register and resolves BEQ/BNE.

---
 rtl/mem_stage_be_pkg.sv | 32 +++
 rtl/mem_stage_be_if.sv | 46 ++++
 rtl/mem_stage_be_ram.sv | 38 +++
 rtl/mem_stage_be.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mem_stage_be_pkg.sv
// Shared definitions for the MEM stage.
//   - memory_bus bit positions (MB_MEMWRITE ... MB_BNE)
//   - IDLE/BUSY state encoding of the wait-state FSM
//   - byte_enable(): byte-lane write mask for SB/SH/SW on a 32-bit word
package mem_stage_pkg;

   localparam int MB_MEMWRITE = 0;
   localparam int MB_MEMREAD  = 1;
   localparam int MB_BRANCH   = 2;
   localparam int MB_UNSIGNED = 3;
   localparam int MB_LH       = 4;
   localparam int MB_LB       = 5;
   localparam int MB_SH       = 6;
   localparam int MB_SB       = 7;
   localparam int MB_BNE      = 8;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // SB wins over SH if both are set, matching the alignment rule in the stage.
   function automatic logic [3:0] byte_enable(input logic sb, input logic sh,
                                              input logic [1:0] off);
      logic [3:0] be;
      if (sb)      be = 4'b0001 << off;
      else if (sh) be = off[1] ? 4'b1100 : 4'b0011;
      else         be = 4'b1111;
      return be;
   endfunction

endpackage

// File: rtl/mem_stage_be_if.sv
// EX/MEM -> MEM/WB bundle of the MEM stage.
//   master: upstream pipeline / hazard unit / debugger side (drives inputs)
//   slave : the MEM stage itself
interface mem_stage_be_if #(
   parameter int len         = 32,
   parameter int NB          = $clog2(len),
   parameter int len_mem_bus = 9,
   parameter int len_wb_bus  = 2,
   parameter int DEPTH       = 2048
);
   // EX/MEM side
   logic [len-1:0]           in_addr_mem;
   logic [len-1:0]           write_data;
   logic [len_mem_bus-1:0]   memory_bus;
   logic [len_wb_bus-1:0]    in_writeBack_bus;
   logic [NB-1:0]            in_write_reg;
   logic                     zero_flag;
   logic [len-1:0]           in_pc_branch;
   logic                     halt_flag_m;
   logic [$clog2(DEPTH)-1:0] dbg_addr;
   // MEM/WB side
   logic [len-1:0]           read_data;
   logic                     pc_src;
   logic [len-1:0]           out_pc_branch;
   logic [len_wb_bus-1:0]    out_writeBack_bus;
   logic [len-1:0]           out_addr_mem;
   logic [NB-1:0]            out_write_reg;
   logic                     out_halt_flag_m;
   logic                     misalign_exc;
   logic                     stall;
   logic [len-1:0]           dbg_data;

   modport master (
      output in_addr_mem, write_data, memory_bus, in_writeBack_bus, in_write_reg,
             zero_flag, in_pc_branch, halt_flag_m, dbg_addr,
      input  read_data, pc_src, out_pc_branch, out_writeBack_bus, out_addr_mem,
             out_write_reg, out_halt_flag_m, misalign_exc, stall, dbg_data
   );

   modport slave (
      input  in_addr_mem, write_data, memory_bus, in_writeBack_bus, in_write_reg,
             zero_flag, in_pc_branch, halt_flag_m, dbg_addr,
      output read_data, pc_src, out_pc_branch, out_writeBack_bus, out_addr_mem,
             out_write_reg, out_halt_flag_m, misalign_exc, stall, dbg_data
   );
endinterface

// File: rtl/mem_stage_be_ram.sv
// ram_be_dp: DEPTH x len single-clock RAM.
//   clk      clock
//   en       port A access enable (read sample and/or write)
//   we       per-byte write enables for port A
//   addr     port A word address
//   wdata    port A write data
//   rdata    port A read data, updated only on enabled edges (read-before-write)
//   dbg_addr debug port word address
//   dbg_data debug port data, asynchronous, no side effects
module ram_be_dp #(
   parameter int len   = 32,
   parameter int DEPTH = 2048
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic [len/8-1:0]         we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [len-1:0]           wdata,
   output logic [len-1:0]           rdata,
   input  logic [$clog2(DEPTH)-1:0] dbg_addr,
   output logic [len-1:0]           dbg_data
);

   logic [len-1:0] mem [DEPTH];

   // NOTE: the array has no reset branch; clearing a RAM on reset would force it into flops.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < len/8; i++) begin
            if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
         rdata <= mem[addr];
      end
   end

   assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/mem_stage_be.sv
// mem_stage_be: MIPS MEM stage with byte-lane stores, offset-aware loads,
// misalignment detection, wait-state FSM with stall output, and debug port.
//   clk, reset   clock and synchronous active-high reset
//   bus (slave)  EX/MEM inputs, MEM/WB registered outputs, pc_src/out_pc_branch,
//                stall to the hazard unit, dbg_addr/dbg_data debug read
// The byte-lane logic assumes a 32-bit word (2-bit byte offset).
module mem_stage_be #(
   parameter int len         = 32,
   parameter int NB          = $clog2(len),
   parameter int len_mem_bus = 9,
   parameter int len_wb_bus  = 2,
   parameter int DEPTH       = 2048,
   parameter int WAIT_STATES = 2
) (
   input  logic          clk,
   input  logic          reset,
   mem_stage_be_if.slave bus
);
   import mem_stage_pkg::*;

   localparam int AW = $clog2(DEPTH);

   // ---------------- decode ----------------
   logic [len_mem_bus-1:0] mbus;
   logic [AW-1:0]          word_idx;
   logic [1:0]             off;
   logic                   mem_write, mem_read, is_sb, is_sh, is_lb, is_lh;
   logic                   store_mis, load_mis, misalign, mem_op;

   assign mbus      = bus.memory_bus;
   assign word_idx  = bus.in_addr_mem[AW+1:2];
   assign off       = bus.in_addr_mem[1:0];
   assign mem_write = mbus[MB_MEMWRITE];
   assign mem_read  = mbus[MB_MEMREAD];
   assign is_sb     = mbus[MB_SB];
   assign is_sh     = mbus[MB_SH];
   assign is_lb     = mbus[MB_LB];
   assign is_lh     = mbus[MB_LH];

   assign store_mis = is_sb ? 1'b0 : (is_sh ? off[0] : (off != 2'b00));
   assign load_mis  = is_lb ? 1'b0 : (is_lh ? off[0] : (off != 2'b00));
   assign misalign  = (mem_write & store_mis) | (mem_read & load_mis);
   // Misaligned ops are not memory ops: they finish at once with no wait states.
   assign mem_op    = (mem_write | mem_read) & ~misalign;

   logic unused_addr_bits;
   assign unused_addr_bits = ^bus.in_addr_mem[len-1:AW+2];

   // ---------------- wait-state FSM ----------------
   state_t state;
   logic [3:0] cnt;
   logic stall_raw, complete;

   // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
   always_comb begin
      stall_raw = 1'b0;
      case (state)
         IDLE:    stall_raw = mem_op && (WAIT_STATES != 0);
         BUSY:    stall_raw = (cnt != 4'd0);
         default: stall_raw = 1'b0;
      endcase
   end

   assign complete  = ~stall_raw;
   assign bus.stall = stall_raw & ~reset;

   // ---------------- RAM ----------------
   logic [3:0]     be;
   logic           ram_en;
   logic [len-1:0] ram_wdata, ram_rdata;
   logic [len/8-1:0] ram_we;

   assign be     = byte_enable(is_sb, is_sh, off);
   // Gating with reset aborts an in-flight access: no write if reset lands on the final edge.
   assign ram_en = mem_op & complete & ~reset;
   assign ram_we = (ram_en && mem_write) ? (len/8)'(be) : '0;

   always_comb begin
      ram_wdata = bus.write_data;
      if (is_sb)      ram_wdata = {(len/8){bus.write_data[7:0]}};
      else if (is_sh) ram_wdata = {(len/16){bus.write_data[15:0]}};
   end

   ram_be_dp #(.len(len), .DEPTH(DEPTH)) u_ram (
      .clk      (clk),
      .en       (ram_en),
      .we       (ram_we),
      .addr     (word_idx),
      .wdata    (ram_wdata),
      .rdata    (ram_rdata),
      .dbg_addr (bus.dbg_addr),
      .dbg_data (bus.dbg_data)
   );

   // ---------------- FSM + MEM/WB register ----------------
   logic [len_wb_bus-1:0] wb_q;
   logic [len-1:0]        addr_q;
   logic [NB-1:0]         wreg_q;
   logic                  halt_q, mis_q;
   logic                  ld_valid, ld_byte, ld_half, ld_unsigned;
   logic [1:0]            ld_off;

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         wb_q        <= '0;
         addr_q      <= '0;
         wreg_q      <= '0;
         halt_q      <= 1'b0;
         mis_q       <= 1'b0;
         ld_valid    <= 1'b0;
         ld_byte     <= 1'b0;
         ld_half     <= 1'b0;
         ld_unsigned <= 1'b0;
         ld_off      <= 2'b00;
      end else begin
         case (state)
            IDLE: if (mem_op && (WAIT_STATES != 0)) begin
                     state <= BUSY;
                     cnt   <= 4'(WAIT_STATES - 1);
                  end
            BUSY: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                  else             state <= IDLE;
            default: state <= IDLE;
         endcase
         // MEM/WB holds while stalled; capture only when the op completes.
         if (complete) begin
            wb_q        <= misalign ? '0 : bus.in_writeBack_bus;
            addr_q      <= bus.in_addr_mem;
            wreg_q      <= bus.in_write_reg;
            halt_q      <= bus.halt_flag_m;
            mis_q       <= misalign;
            // A simultaneous write wins, so such a read returns 0.
            ld_valid    <= mem_op & mem_read & ~mem_write;
            ld_byte     <= is_lb;
            ld_half     <= is_lh;
            ld_unsigned <= mbus[MB_UNSIGNED];
            ld_off      <= off;
         end
      end
   end

   // ---------------- load formatting ----------------
   // Function of registered state only: the RAM word and load controls captured together.
   logic [7:0]     ld_b;
   logic [15:0]    ld_h;
   logic [len-1:0] rd_fmt;

   always_comb begin
      ld_b   = ram_rdata[{ld_off, 3'b000} +: 8];
      ld_h   = ram_rdata[{ld_off[1], 4'b0000} +: 16];
      rd_fmt = '0;
      if (ld_valid) begin
         if (ld_byte)      rd_fmt = ld_unsigned ? {{(len-8){1'b0}}, ld_b}
                                                : {{(len-8){ld_b[7]}}, ld_b};
         else if (ld_half) rd_fmt = ld_unsigned ? {{(len-16){1'b0}}, ld_h}
                                                : {{(len-16){ld_h[15]}}, ld_h};
         else              rd_fmt = ram_rdata;
      end
   end

   // ---------------- outputs ----------------
   assign bus.read_data         = rd_fmt;
   assign bus.out_writeBack_bus = wb_q;
   assign bus.out_addr_mem      = addr_q;
   assign bus.out_write_reg     = wreg_q;
   assign bus.out_halt_flag_m   = halt_q;
   assign bus.misalign_exc      = mis_q;
   assign bus.out_pc_branch     = bus.in_pc_branch;
   assign bus.pc_src = mbus[MB_BRANCH] & (mbus[MB_BNE] ? ~bus.zero_flag : bus.zero_flag);

endmodule
